// File: rtl/dispatch_queue.sv
// Instruction dispatch queue: buffers decoded instructions and issues one per cycle from the head
// to the ALU, branch or load/store reservation station, resolving operands on the way out.
module dispatch_queue #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6,
  parameter int NUM_CDB = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_class,
  input  logic [OP_W-1:0]          in_op,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  input  logic [31:0]              in_imm,
  input  logic [31:0]              in_addr,
  output logic [4:0]               rs1_name,
  output logic [4:0]               rs2_name,
  input  logic [TAG_W-1:0]         reg_tag1,
  input  logic [TAG_W-1:0]         reg_tag2,
  input  logic [31:0]              reg_data1,
  input  logic [31:0]              reg_data2,
  input  logic                     rob_rdy1,
  input  logic                     rob_rdy2,
  input  logic [31:0]              rob_data1,
  input  logic [31:0]              rob_data2,
  input  logic [TAG_W-1:0]         rob_free_tag,
  input  logic                     rob_full,
  input  logic                     alu_full,
  input  logic                     br_full,
  input  logic                     ls_full,
  input  logic [NUM_CDB-1:0]       cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0] cdb_tag,
  input  logic [NUM_CDB*32-1:0]    cdb_data,
  output logic                     disp_en,
  output logic                     wrt_en,
  output logic [4:0]               wrt_name,
  output logic [TAG_W-1:0]         wrt_tag,
  output logic                     alu_en,
  output logic                     br_en,
  output logic                     ls_en,
  output logic [OP_W-1:0]          op,
  output logic [31:0]              operand1,
  output logic [31:0]              operand2,
  output logic [TAG_W-1:0]         tag1,
  output logic [TAG_W-1:0]         tag2,
  output logic [31:0]              imm,
  output logic [31:0]              addr,
  output logic [TAG_W-1:0]         rob_tag,
  output logic [4:0]               rd_name
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [3:0] C_LUI = 4'd1, C_AUIPC = 4'd2, C_JAL = 4'd3, C_JALR = 4'd4, C_B = 4'd5;
  localparam logic [3:0] C_LD  = 4'd6, C_ST    = 4'd7, C_RI  = 4'd8, C_RR   = 4'd9;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } opnd_t;

  logic [3:0]       cls_mem  [DEPTH];
  logic [OP_W-1:0]  op_mem   [DEPTH];
  logic [4:0]       rd_mem   [DEPTH];
  logic [4:0]       rs1_mem  [DEPTH];
  logic [4:0]       rs2_mem  [DEPTH];
  logic [31:0]      imm_mem  [DEPTH];
  logic [31:0]      addr_mem [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             alu_en_q, br_en_q, ls_en_q;
  logic [OP_W-1:0]  op_q;
  logic [31:0]      op1_q, op2_q, imm_q, addr_q;
  logic [TAG_W-1:0] t1_q, t2_q, rtag_q;
  logic [4:0]       rd_q;

  logic [3:0]       h_cls;
  logic [4:0]       h_rd;
  logic [31:0]      h_imm, h_addr;
  logic             cls_ok, to_alu, to_br, to_ls, rs_full, nonempty;
  logic             head_ok, fire, pop, push;
  opnd_t            src1, src2, op1_d, op2_d;
  logic [4:0]       rd_d;

  // Lowest channel wins: scan high-to-low so the last overwrite is channel 0.
  function automatic logic [32:0] cdb_lookup(input logic [TAG_W-1:0] t);
    logic [32:0] r;
    r = '0;
    for (int i = NUM_CDB - 1; i >= 0; i--) begin
      if (cdb_valid[i] && (cdb_tag[i*TAG_W +: TAG_W] == t)) r = {1'b1, cdb_data[i*32 +: 32]};
    end
    return r;
  endfunction

  function automatic opnd_t resolve(input logic [4:0] name, input logic [TAG_W-1:0] rtag,
                                    input logic [31:0] rdata, input logic rrdy,
                                    input logic [31:0] rbdata);
    opnd_t       r;
    logic [32:0] c;
    c      = cdb_lookup(rtag);
    r.tag  = '0;
    r.data = '0;
    if (name == 5'd0)      r.data = '0;
    else if (rtag == '0)   r.data = rdata;
    else if (rrdy)         r.data = rbdata;
    else if (c[32])        r.data = c[31:0];
    else                   r.tag  = rtag;
    return r;
  endfunction

  assign h_cls    = cls_mem[head_q];
  assign h_rd     = rd_mem[head_q];
  assign h_imm    = imm_mem[head_q];
  assign h_addr   = addr_mem[head_q];
  assign rs1_name = rs1_mem[head_q];
  assign rs2_name = rs2_mem[head_q];

  assign in_ready = (count_q < CNT_W'(DEPTH));
  assign nonempty = (count_q != '0);
  assign cls_ok   = (h_cls >= C_LUI) && (h_cls <= C_RR);
  assign to_br    = (h_cls == C_B);
  assign to_ls    = (h_cls == C_LD) || (h_cls == C_ST);
  assign to_alu   = cls_ok && !to_br && !to_ls;
  assign rs_full  = (to_alu && alu_full) || (to_br && br_full) || (to_ls && ls_full);
  assign head_ok  = nonempty && cls_ok && !rob_full && !rs_full;
  assign fire     = head_ok && !flush;
  // Invalid classes are discarded at the head without touching the ROB or regfile.
  assign pop      = fire || (nonempty && !cls_ok && !flush);
  assign push     = in_valid && in_ready && !flush;

  assign disp_en  = fire;
  assign wrt_en   = fire && (h_cls != C_B) && (h_cls != C_ST) && (h_rd != 5'd0);
  assign wrt_name = h_rd;
  assign wrt_tag  = rob_free_tag;

  always_comb begin
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  always_comb begin
    src1  = resolve(rs1_name, reg_tag1, reg_data1, rob_rdy1, rob_data1);
    src2  = resolve(rs2_name, reg_tag2, reg_data2, rob_rdy2, rob_data2);
    op1_d = '0;
    op2_d = '0;
    case (h_cls)
      C_LUI:          op2_d.data = h_imm;
      C_AUIPC, C_JAL: begin op1_d.data = h_addr; op2_d.data = h_imm; end
      C_JALR, C_RI:   begin op1_d = src1; op2_d.data = h_imm; end
      C_LD:           op1_d = src1;
      C_B, C_ST, C_RR: begin op1_d = src1; op2_d = src2; end
      default:        ;
    endcase
    rd_d = ((h_cls == C_B) || (h_cls == C_ST)) ? 5'd0 : h_rd;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      cls_mem[tail_q]  <= in_class;
      op_mem[tail_q]   <= in_op;
      rd_mem[tail_q]   <= in_rd;
      rs1_mem[tail_q]  <= in_rs1;
      rs2_mem[tail_q]  <= in_rs2;
      imm_mem[tail_q]  <= in_imm;
      addr_mem[tail_q] <= in_addr;
    end
  end

  // Head dispatch -> RS output stage
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      alu_en_q <= 1'b0;
      br_en_q  <= 1'b0;
      ls_en_q  <= 1'b0;
      op_q     <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      t1_q     <= '0;
      t2_q     <= '0;
      imm_q    <= '0;
      addr_q   <= '0;
      rtag_q   <= '0;
      rd_q     <= '0;
    end else if (flush) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      alu_en_q <= 1'b0;
      br_en_q  <= 1'b0;
      ls_en_q  <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      alu_en_q <= fire && to_alu;
      br_en_q  <= fire && to_br;
      ls_en_q  <= fire && to_ls;
      if (fire) begin
        op_q   <= op_mem[head_q];
        op1_q  <= op1_d.data;
        op2_q  <= op2_d.data;
        t1_q   <= op1_d.tag;
        t2_q   <= op2_d.tag;
        imm_q  <= h_imm;
        addr_q <= h_addr;
        rtag_q <= rob_free_tag;
        rd_q   <= rd_d;
      end
    end
  end

  logic        strobe;
  logic [32:0] snoop1, snoop2;
  logic        hit1, hit2;

  // A broadcast landing during the handoff cycle is forwarded so the RS never misses it.
  assign strobe   = alu_en_q || br_en_q || ls_en_q;
  assign snoop1   = cdb_lookup(t1_q);
  assign snoop2   = cdb_lookup(t2_q);
  assign hit1     = strobe && (t1_q != '0) && snoop1[32];
  assign hit2     = strobe && (t2_q != '0) && snoop2[32];
  assign operand1 = hit1 ? snoop1[31:0] : op1_q;
  assign operand2 = hit2 ? snoop2[31:0] : op2_q;
  assign tag1     = hit1 ? '0 : t1_q;
  assign tag2     = hit2 ? '0 : t2_q;

  assign alu_en  = alu_en_q;
  assign br_en   = br_en_q;
  assign ls_en   = ls_en_q;
  assign op      = op_q;
  assign imm     = imm_q;
  assign addr    = addr_q;
  assign rob_tag = rtag_q;
  assign rd_name = rd_q;

endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- Parametrised successor to the single-slot combinational dispatcher.
- Buffers decoded instructions in a DEPTH-entry FIFO and dispatches at most one per cycle from the head to the ALU, branch or load/store reservation station.
- Dispatch happens only when the ROB and the target RS can accept it.
- On dispatch: allocates the ROB tag, renames rd in the regfile, resolves operands from regfile, ROB and NUM_CDB broadcast buses, and registers the RS-facing outputs.

Parameters:
DEPTH, 4, queue entries; power of 2, ≥2
TAG_W, 4, tag width; tag 0 = "no dependency / value ready"
OP_W, 6, opcode width
NUM_CDB, 2, number of common-data-bus broadcast channels

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  misprediction flush
in_valid  in  1  decoder offers an instruction
in_ready  out  1  queue can accept: count<DEPTH
in_class  in  4  0 none, 1 LUI, 2 AUIPC, 3 JAL, 4 JALR, 5 B, 6 LD, 7 ST, 8 RI, 9 RR
in_op  in  OP_W  opcode
in_rd / in_rs1 / in_rs2  in  5 each  register names
in_imm  in  32  class-appropriate immediate, already selected by decoder
in_addr  in  32  instruction address
rs1_name / rs2_name  out  5 each  combinational regfile read names (queue head)
reg_tag1 / reg_tag2  in  TAG_W each  regfile rename tags
reg_data1 / reg_data2  in  32 each  regfile data
rob_rdy1 / rob_rdy2  in  1 each  ROB holds finished value for reg_tagN
rob_data1 / rob_data2  in  32 each  that value
rob_free_tag  in  TAG_W  next ROB tag (non-zero)
rob_full  in  1  ROB cannot allocate
alu_full / br_full / ls_full  in  1 each  RS cannot accept
cdb_valid  in  NUM_CDB  broadcast valid per channel
cdb_tag  in  NUM_CDB*TAG_W  flat, channel 0 in LSBs
cdb_data  in  NUM_CDB*32  flat
disp_en  out  1  ROB allocate (combinational, = fire)
wrt_en  out  1  regfile rename (combinational)
wrt_name  out  5  rd of head
wrt_tag  out  TAG_W  = rob_free_tag
alu_en / br_en / ls_en  out  1 each  registered RS write strobes
op  out  OP_W  registered opcode
operand1 / operand2  out  32 each  operand data
tag1 / tag2  out  TAG_W each  operand tags
imm  out  32  immediate
addr  out  32  instruction address
rob_tag  out  TAG_W  destination ROB tag
rd_name  out  5  destination register; 0 for B/ST

Behaviour:
- Reset: queue empty; alu_en, br_en and ls_en = 0; all registered data outputs = 0.
- Push: in_valid && in_ready && !flush writes the tail entry.
- head_ok: count>0 && head class in 1..9 && !rob_full && target RS not full.
  - Target RS: classes 1-4 and 8-9 → ALU; class 5 → branch; classes 6-7 → LS.
- fire = head_ok && !flush; pops the head.
- A head with class 0 or a class >9 is popped without dispatch; disp_en and wrt_en stay 0.
- Push and pop in the same cycle leave count unchanged; pointers wrap modulo DEPTH.
- disp_en = fire.
- wrt_en = fire && class not in {B, ST} && rd≠0. rd=0 still consumes a ROB tag.
- Operand resolution at fire, in priority order:
  1. Register name 0 → data 0, tag 0.
  2. reg_tag=0 → reg_data.
  3. rob_rdy → rob_data, tag 0.
  4. Any cdb_valid[i] with cdb_tag[i]==reg_tag → cdb_data[i], tag 0 (lowest channel wins).
  5. Otherwise data 0, tag reg_tag.
- Operand selection by class:
  - LUI: op1 = 0 / tag 0; op2 = imm.
  - AUIPC, JAL: op1 = addr; op2 = imm.
  - JALR, RI, LD: op1 = rs1; op2 = imm.
    - LD: op2 = 0 and imm out = in_imm.
  - B, ST, RR: op1 = rs1; op2 = rs2.
    - B, ST: imm out = in_imm.
- Latency: operands and strobes are registered at the fire edge and held for exactly one cycle (strobes pulse).
- Output-stage snoop: while a strobe is high, a CDB match on a nonzero tag1/tag2 substitutes cdb_data combinationally and drives that tag to 0. The RS therefore never misses a broadcast in the handoff cycle.
- Back-to-back dependence: the rename is written at the fire edge, so the next head reads the new tag. No internal bypass is needed.
- flush:
  - Empties the queue at the next edge.
  - Suppresses fire, disp_en, wrt_en and push in the flush cycle.
  - Clears the strobes at the next edge.
  - Takes priority over every other event.
- rst mid-operation behaves identically to flush and additionally zeroes the data outputs.

Test Plan:
- Reset, then push RI (rs1=3, reg_tag1=0, reg_data1=7, imm=5, rob_free_tag=2) → next cycle alu_en=1, operand1=7, operand2=5, tag1=0, rob_tag=2; wrt_en was 1 with wrt_tag=2.
- Push 5 instructions with DEPTH=4 while alu_full=1 → in_ready=0 after the 4th; release alu_full → one dispatch per cycle, in order.
- RR with reg_tag2=6, rob_rdy2=0, cdb_valid=2'b10, cdb_tag[1]=6, cdb_data[1]=0x55 at fire → tag2=0, operand2=0x55.
- Output cycle with tag1=9 and cdb channel 0 broadcasting tag 9 / data 0x11 → operand1=0x11, tag1=0 that cycle.
- ST with rob_full=1 → disp_en=0 and the entry is held; rob_full falls → ls_en=1, rd_name=0, wrt_en=0.
- Queue holds 3 entries and flush is asserted together with in_valid → next cycle count=0, no strobes, new instruction not queued.
